// File: rtl/rip_csr_unit.sv
// Machine-mode CSR unit: Zicsr ops, trap entry/MRET, mcycle/minstret.
// Define RIP_CSR_VECTORED_EN for vectored mtvec mode.
module rip_csr_unit #(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [2:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_src_zero,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            retire,
    input  logic            irq_ext,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_pending
);
    localparam int DW = 2 * XLEN;

    logic            st_mie, st_mpie, ie_meie;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [CNT_W-1:0] mcycle_q, minstret_q;
    logic [DW-1:0]   cyc_x, ins_x;
    logic [XLEN-1:0] old_val, new_val;
    logic            mapped, is_write, wr_en;

    function automatic logic [XLEN-1:0] legal_tvec(input logic [XLEN-1:0] v);
`ifdef RIP_CSR_VECTORED_EN
        return v[1] ? {v[XLEN-1:2], 2'b00} : v;
`else
        return {v[XLEN-1:2], 2'b00};
`endif
    endfunction

    assign cyc_x = DW'(mcycle_q);
    assign ins_x = DW'(minstret_q);

    always_comb begin
        old_val = '0;
        mapped  = 1'b1;
        unique case (csr_addr)
            12'h300: begin
                old_val[12:11] = 2'b11;
                old_val[7]     = st_mpie;
                old_val[3]     = st_mie;
            end
            12'h301: old_val = XLEN'(32'h4000_1100);
            12'h304: old_val[11] = ie_meie;
            12'h305: old_val = mtvec_q;
            12'h340: old_val = mscratch_q;
            12'h341: old_val = mepc_q;
            12'h342: old_val = mcause_q;
            12'h344: old_val[11] = irq_ext;
            12'hB00, 12'hC00: old_val = cyc_x[XLEN-1:0];
            12'hB80, 12'hC80: old_val = cyc_x[DW-1:XLEN];
            12'hB02, 12'hC02: old_val = ins_x[XLEN-1:0];
            12'hB82, 12'hC82: old_val = ins_x[DW-1:XLEN];
            12'hF14: old_val = '0;
            default: mapped = 1'b0;
        endcase
    end

    // set/clear forms with a zero source are pure reads
    always_comb begin
        is_write = 1'b0;
        new_val  = csr_wdata;
        unique case (csr_op[1:0])
            2'b01: is_write = 1'b1;
            2'b10: begin
                is_write = ~csr_src_zero;
                new_val  = old_val | csr_wdata;
            end
            2'b11: begin
                is_write = ~csr_src_zero;
                new_val  = old_val & ~csr_wdata;
            end
            default: is_write = 1'b0;
        endcase
    end

    assign csr_illegal = csr_valid &
        (~mapped | (is_write & (csr_addr[11:10] == 2'b11)));
    assign csr_rdata   = csr_valid ? old_val : '0;
    assign wr_en       = csr_valid & ~csr_illegal & is_write &
                         ~trap_valid & ~mret_valid;
    assign mepc_out    = mepc_q;
    assign irq_pending = st_mie & ie_meie & irq_ext;

    always_comb begin
        trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
`ifdef RIP_CSR_VECTORED_EN
        if (mtvec_q[1:0] == 2'b01 && trap_cause[XLEN-1])
            trap_vector = {mtvec_q[XLEN-1:2], 2'b00} +
                          {trap_cause[XLEN-3:0], 2'b00};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            ie_meie    <= 1'b0;
            mtvec_q    <= legal_tvec(MTVEC_RESET);
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_q + CNT_W'(1);
            minstret_q <= minstret_q + CNT_W'(retire);
            if (trap_valid) begin
                mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause_q <= trap_cause;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else if (mret_valid) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr_en) begin
                // counter half writes override the increment above
                case (csr_addr)
                    12'h300: begin
                        st_mie  <= new_val[3];
                        st_mpie <= new_val[7];
                    end
                    12'h304: ie_meie    <= new_val[11];
                    12'h305: mtvec_q    <= legal_tvec(new_val);
                    12'h340: mscratch_q <= new_val;
                    12'h341: mepc_q     <= {new_val[XLEN-1:2], 2'b00};
                    12'h342: mcause_q   <= new_val;
                    12'hB00: mcycle_q <= CNT_W'({cyc_x[DW-1:XLEN], new_val});
                    12'hB80: mcycle_q <= CNT_W'({new_val, cyc_x[XLEN-1:0]});
                    12'hB02: minstret_q <= CNT_W'({ins_x[DW-1:XLEN], new_val});
                    12'hB82: minstret_q <= CNT_W'({new_val, ins_x[XLEN-1:0]});
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rip_csr_unit.sv
// Randomized bench for rip_csr_unit against a behavioural CSR model.
module tb_rip_csr_unit;
    localparam int          CNT_W     = 64;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0200;

    logic        clk, rst;
    logic        csr_valid, csr_src_zero, csr_illegal;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        trap_valid, mret_valid, retire, irq_ext, irq_pending;
    logic [31:0] trap_cause, trap_pc, trap_vector, mepc_out;

    rip_csr_unit #(
        .XLEN(32), .CNT_W(CNT_W), .MTVEC_RESET(MTVEC_RST)
    ) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_src_zero(csr_src_zero),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .mret_valid(mret_valid), .retire(retire),
        .irq_ext(irq_ext), .trap_vector(trap_vector),
        .mepc_out(mepc_out), .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // reference state
    bit        m_mie, m_mpie, m_meie;
    bit [31:0] m_tvec, m_scr, m_epc, m_cause;
    bit [63:0] m_cyc, m_ins;

    localparam bit [11:0] MAP [17] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
        12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
        12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14
    };

    function automatic bit [63:0] cmask();
        bit [63:0] m = '1;
        if (CNT_W < 64) m = (64'd1 << CNT_W) - 64'd1;
        return m;
    endfunction

    function automatic bit [31:0] tvec_legal(bit [31:0] v);
`ifdef RIP_CSR_VECTORED_EN
        return v[1] ? (v & ~32'd3) : v;
`else
        return v & ~32'd3;
`endif
    endfunction

    function automatic bit is_mapped(bit [11:0] a);
        foreach (MAP[i]) if (MAP[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [31:0] m_read(bit [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return 32'h4000_1100;
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_tvec;
            12'h340: return m_scr;
            12'h341: return m_epc;
            12'h342: return m_cause;
            12'h344: return 32'(irq_ext) << 11;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_wr(bit [2:0] op, bit sz);
        if (op == 3'd1 || op == 3'd5) return 1'b1;
        if (op == 3'd0 || op == 3'd4) return 1'b0;
        return !sz;
    endfunction

    function automatic bit m_ill(bit v, bit [2:0] op, bit [11:0] a, bit sz);
        return v && (!is_mapped(a) || (m_wr(op, sz) && a >= 12'hC00));
    endfunction

    function automatic bit [31:0] m_tv(bit [31:0] cause);
        bit [31:0] base = m_tvec & ~32'd3;
`ifdef RIP_CSR_VECTORED_EN
        if ((m_tvec & 32'd3) == 32'd1 && cause[31])
            return base + cause * 32'd4;
`endif
        return base;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0;
        m_tvec = tvec_legal(MTVEC_RST);
        m_scr = 0; m_epc = 0; m_cause = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic drive(bit v, bit [2:0] op, bit [11:0] a, bit [31:0] wd,
                         bit sz, bit tv, bit [31:0] tc, bit [31:0] tp,
                         bit mv, bit ret, bit irq);
        csr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
        csr_src_zero = sz; trap_valid = tv; trap_cause = tc;
        trap_pc = tp; mret_valid = mv; retire = ret; irq_ext = irq;
        #1;
        chk("rdata", csr_rdata, v ? m_read(a) : 32'd0);
        chk("illegal", 32'(csr_illegal), 32'(m_ill(v, op, a, sz)));
        chk("trap_vector", trap_vector, m_tv(tc));
        chk("mepc_out", mepc_out, m_epc);
        chk("irq_pending", 32'(irq_pending), 32'(m_mie & m_meie & irq));
    endtask

    task automatic adv();
        bit [31:0] old, nv;
        bit [63:0] c0, i0;
        bit ill;
        old = m_read(csr_addr);
        ill = m_ill(csr_valid, csr_op, csr_addr, csr_src_zero);
        case (csr_op[1:0])
            2'b10: nv = old | csr_wdata;
            2'b11: nv = old & ~csr_wdata;
            default: nv = csr_wdata;
        endcase
        c0 = m_cyc; i0 = m_ins;
        m_cyc = (m_cyc + 64'd1) & cmask();
        m_ins = (m_ins + 64'(retire)) & cmask();
        if (trap_valid) begin
            m_epc = trap_pc & ~32'd3;
            m_cause = trap_cause;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (mret_valid) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end else if (csr_valid && !ill && m_wr(csr_op, csr_src_zero)) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_meie = nv[11];
                12'h305: m_tvec = tvec_legal(nv);
                12'h340: m_scr = nv;
                12'h341: m_epc = nv & ~32'd3;
                12'h342: m_cause = nv;
                12'hB00: m_cyc = {c0[63:32], nv} & cmask();
                12'hB80: m_cyc = {nv, c0[31:0]} & cmask();
                12'hB02: m_ins = {i0[63:32], nv} & cmask();
                12'hB82: m_ins = {nv, i0[31:0]} & cmask();
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        bit [11:0] a;
        bit [31:0] wd;
        bit        sz;
        int        k;
        rst = 1'b1;
        csr_valid = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        csr_src_zero = 0; trap_valid = 0; trap_cause = 0; trap_pc = 0;
        mret_valid = 0; retire = 0; irq_ext = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        drive(0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rdata", csr_rdata, 32'd0);
        chk("rst_tvec", trap_vector, MTVEC_RST);
        adv();
        drive(1, 3'd2, 12'h300, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mstatus_rst", csr_rdata, 32'h0000_1800);
        adv();
        drive(1, 3'd2, 12'h305, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mtvec_rst", csr_rdata, MTVEC_RST);
        adv();

        drive(1, 3'd1, 12'h340, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0);
        adv();
        drive(1, 3'd3, 12'h340, 32'h0000FFFF, 0, 0, 0, 0, 0, 1, 0);
        chk("rc_old", csr_rdata, 32'hDEADBEEF);
        adv();
        drive(1, 3'd2, 12'h340, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rc_new", csr_rdata, 32'hDEAD0000);
        adv();

        drive(1, 3'd2, 12'h300, 32'h8, 0, 0, 0, 0, 0, 0, 1);
        adv();
        drive(1, 3'd2, 12'h304, 32'h800, 0, 0, 0, 0, 0, 0, 1);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("irq_on", 32'(irq_pending), 32'd1);
        adv();
        drive(0, 0, 0, 0, 0, 1, 32'h8000000B, 32'h102, 0, 1, 1);
        adv();
        drive(1, 3'd2, 12'h300, 0, 1, 0, 0, 0, 0, 0, 1);
        chk("trap_mepc", mepc_out, 32'h100);
        chk("trap_irq", 32'(irq_pending), 32'd0);
        chk("trap_mstatus", csr_rdata, 32'h1880);
        adv();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        adv();
        drive(1, 3'd2, 12'h300, 0, 1, 0, 0, 0, 0, 0, 1);
        chk("mret_mstatus", csr_rdata, 32'h1888);
        adv();

        drive(1, 3'd1, 12'hB00, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        adv();
        drive(1, 3'd1, 12'hB80, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        drive(1, 3'd2, 12'hB00, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mcycle_max", csr_rdata, 32'hFFFFFFFF);
        adv();
        drive(1, 3'd2, 12'hB80, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("mcycleh_carry", csr_rdata, 32'h1);
        adv();
        drive(1, 3'd1, 12'hC00, 32'h5, 0, 0, 0, 0, 0, 0, 0);
        chk("ro_write_ill", 32'(csr_illegal), 32'd1);
        adv();
        drive(1, 3'd2, 12'hC00, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("ro_read_ok", 32'(csr_illegal), 32'd0);
        adv();

        drive(1, 3'd1, 12'h341, 32'h12345678, 0, 1, 32'h2, 32'hABE, 1, 0, 0);
        adv();
        drive(1, 3'd2, 12'h341, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("prio_mepc", csr_rdata, 32'h0ABC);
        adv();
        drive(1, 3'd2, 12'h300, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("prio_mie", csr_rdata & 32'h8, 32'h0);
        adv();

        drive(1, 3'd1, 12'h305, 32'h1001, 0, 0, 0, 0, 0, 0, 0);
        adv();
        drive(1, 3'd2, 12'h305, 0, 1, 0, 32'h80000007, 0, 0, 0, 0);
`ifdef RIP_CSR_VECTORED_EN
        chk("vec_mtvec", csr_rdata, 32'h1001);
        chk("vec_target", trap_vector, 32'h101C);
`else
        chk("vec_mtvec", csr_rdata, 32'h1000);
        chk("vec_target", trap_vector, 32'h1000);
`endif
        adv();

        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 19);
            a = (k < 17) ? MAP[k] : 12'h7C0 + 12'(k);
            sz = ($urandom_range(0, 3) == 0);
            wd = sz ? 32'd0 : $urandom;
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a, wd,
                  sz, $urandom_range(0, 9) == 0, $urandom, $urandom,
                  $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom));
            adv();
        end

        drive(1, 3'd1, 12'h340, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_mepc", mepc_out, 32'd0);
        chk("arst_rdata", csr_rdata, 32'd0);
        chk("arst_tvec", trap_vector, MTVEC_RST);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3'd2, 12'h340, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("arst_scratch", csr_rdata, 32'd0);
        adv();
        drive(1, 3'd2, 12'hB00, 0, 1, 0, 0, 0, 0, 0, 0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
